// File: rtl/kiwi_io_pkg.sv
// Shared definitions for the Kiwi board I/O blocks: board clock rate,
// debounce timing defaults and the per-key debounce state encoding.
package kiwi_io_pkg;

  // Board clock frequency, used to express timing defaults in cycles.
  localparam int KIWI_CLK_HZ = 50_000_000;

  // 20 ms of stable input before a level change is accepted.
  localparam int DEFAULT_DEBOUNCE_CYCLES = KIWI_CLK_HZ / 50;

  // 1 s of continuous press before a long-press event fires.
  localparam int DEFAULT_LONG_PRESS_CYCLES = KIWI_CLK_HZ;

  // Per-key debounce states. The pending states hold a candidate level
  // that has not yet been stable for the full debounce window.
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } key_state_t;

endpackage

// File: rtl/button_debouncer_if.sv
// Pushbutton bundle: raw pins in, debounced levels and events out.
// The board side (pins, consumers) is the master; the debouncer is the slave.
interface button_debouncer_if #(
  parameter int NUM_KEYS = 4
);

  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic                key_any;

  modport master (
    output KEY,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_any
  );

  modport slave (
    input  KEY,
    output key_state,
    output key_press,
    output key_release,
    output key_long,
    output key_any
  );

endinterface

// File: rtl/key_debounce_channel.sv
// One pushbutton: synchronizer, polarity normalization, debounce FSM and
// hold timer. Every output is a flop so downstream logic sees clean pulses.
module key_debounce_channel
  import kiwi_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic CLK_50,
  input  logic RST,
  input  logic key_raw,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int STABLE_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W   = $clog2(LONG_PRESS_CYCLES + 1);

  // Raw pin level that means "not pressed".
  localparam logic IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

  // A pending change commits on the sample that would bring the stable
  // count to DEBOUNCE_CYCLES, i.e. when the current count is one below it.
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]   HOLD_MAX    = HOLD_W'(LONG_PRESS_CYCLES);

  // With a one-sample window the pending states are skipped entirely.
  localparam bit INSTANT_COMMIT = (DEBOUNCE_CYCLES == 1);

  logic [1:0]          sync_q;
  logic                pressed_in;
  key_state_t          state;
  logic [STABLE_W-1:0] stable_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  // Two-flop synchronizer, reset to the idle pin level so that a key held
  // through reset is seen as a fresh press.
  // NOTE: sequential logic uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of block order.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) sync_q <= {2{IDLE_LEVEL}};
    else     sync_q <= {sync_q[0], key_raw};
  end

  // Normalized input: 1 = pressed regardless of pin polarity.
  assign pressed_in = sync_q[1] ^ IDLE_LEVEL;

  // Debounce FSM plus saturating hold timer, with registered outputs.
  always_ff @(posedge CLK_50 or posedge RST) begin
    if (RST) begin
      state       <= RELEASED;
      stable_cnt  <= '0;
      hold_cnt    <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;

      // Hold timer runs while the debounced level is pressed and stops at
      // its limit, so the long-press pulse fires once with no auto-repeat.
      // A release commit below overrides both the count and the pulse.
      if ((state == PRESSED || state == RELEASE_PENDING) && hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
        key_long <= (hold_cnt == HOLD_MAX - HOLD_W'(1));
      end

      unique case (state)
        RELEASED: begin
          if (pressed_in) begin
            if (INSTANT_COMMIT) begin
              state      <= PRESSED;
              key_state  <= 1'b1;
              key_press  <= 1'b1;
              stable_cnt <= '0;
              hold_cnt   <= '0;
            end else begin
              state      <= PRESS_PENDING;
              stable_cnt <= STABLE_W'(1);
            end
          end
        end

        PRESS_PENDING: begin
          if (!pressed_in) begin
            // Bounce: abandon the candidate press silently.
            state      <= RELEASED;
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state      <= PRESSED;
            key_state  <= 1'b1;
            key_press  <= 1'b1;
            stable_cnt <= '0;
            hold_cnt   <= '0;
          end else begin
            stable_cnt <= stable_cnt + STABLE_W'(1);
          end
        end

        PRESSED: begin
          if (!pressed_in) begin
            if (INSTANT_COMMIT) begin
              state       <= RELEASED;
              key_state   <= 1'b0;
              key_release <= 1'b1;
              key_long    <= 1'b0;
              stable_cnt  <= '0;
              hold_cnt    <= '0;
            end else begin
              state      <= RELEASE_PENDING;
              stable_cnt <= STABLE_W'(1);
            end
          end
        end

        RELEASE_PENDING: begin
          if (pressed_in) begin
            // Bounce: the key is still held, keep the hold timer running.
            state      <= PRESSED;
            stable_cnt <= '0;
          end else if (stable_cnt == STABLE_LAST) begin
            state       <= RELEASED;
            key_state   <= 1'b0;
            key_release <= 1'b1;
            key_long    <= 1'b0;
            stable_cnt  <= '0;
            hold_cnt    <= '0;
          end else begin
            stable_cnt <= stable_cnt + STABLE_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Kiwi pushbutton front end: one independent debounce channel per key and
// a combined "any key held" flag.
module button_debouncer
  import kiwi_io_pkg::*;
#(
  parameter int NUM_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic             CLK_50,
  input  logic             RST,
  button_debouncer_if.slave io
);

  logic [NUM_KEYS-1:0] state_vec;

  // One self-contained channel per key; keys never interact.
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .ACTIVE_LOW       (ACTIVE_LOW)
    ) u_channel (
      .CLK_50     (CLK_50),
      .RST        (RST),
      .key_raw    (io.KEY[i]),
      .key_state  (state_vec[i]),
      .key_press  (io.key_press[i]),
      .key_release(io.key_release[i]),
      .key_long   (io.key_long[i])
    );
  end

  assign io.key_state = state_vec;

  // OR of the per-key state flops: it moves on the same edge as key_state
  // and drops with them as soon as RST asserts.
  assign io.key_any = |state_vec;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-low and an active-high instance
// driven with the same logical key activity, both compared every cycle
// against a run-length reference model of the debounce rules.
module tb_button_debouncer;
  import kiwi_io_pkg::*;

  localparam int NK   = 4;
  localparam int DEB  = 8;
  localparam int LONG = 32;

  logic          CLK_50 = 1'b0;
  logic          RST    = 1'b1;
  logic [NK-1:0] pressed = '0;   // logical key activity, 1 = pressed

  button_debouncer_if #(.NUM_KEYS(NK)) io_lo ();
  button_debouncer_if #(.NUM_KEYS(NK)) io_hi ();

  assign io_lo.KEY = ~pressed;
  assign io_hi.KEY = pressed;

  button_debouncer #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b1)
  ) dut_lo (
    .CLK_50(CLK_50), .RST(RST), .io(io_lo)
  );

  button_debouncer #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_PRESS_CYCLES(LONG), .ACTIVE_LOW(1'b0)
  ) dut_hi (
    .CLK_50(CLK_50), .RST(RST), .io(io_hi)
  );

  always #10 CLK_50 = ~CLK_50;

  // ---------------- reference model ----------------
  // Input reaches the decision logic two edges after the pin is sampled.
  // A level change is accepted once DEB consecutive samples disagree with
  // the accepted level; a press is "long" once it has been accepted for
  // LONG edges without an accepted release.
  logic [NK-1:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;
  logic [NK-1:0] dly0 = '0, dly1 = '0;
  int            m_run  [NK];
  int            m_hold [NK];

  initial begin
    for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end
    forever begin
      @(posedge CLK_50 or posedge RST);
      if (RST) begin
        m_state = '0; m_press = '0; m_rel = '0; m_long = '0;
        dly0 = '0; dly1 = '0;
        for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_hold[k] = 0; end
      end else begin
        logic [NK-1:0] seen;
        seen = dly1; dly1 = dly0; dly0 = pressed;
        m_press = '0; m_rel = '0; m_long = '0;
        for (int k = 0; k < NK; k++) begin
          logic was;
          was = m_state[k];
          if (seen[k] != was) begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == DEB) begin
              m_state[k] = ~was;
              m_run[k]   = 0;
              m_hold[k]  = 0;
              if (was) m_rel[k] = 1'b1; else m_press[k] = 1'b1;
            end
          end else begin
            m_run[k] = 0;
          end
          if (was && m_state[k] && m_hold[k] < LONG) begin
            m_hold[k] = m_hold[k] + 1;
            if (m_hold[k] == LONG) m_long[k] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  int press_cnt[NK], rel_cnt[NK], long_cnt[NK];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0; end
  endtask

  // One cycle: wait for the falling edge, compare both DUTs to the model.
  task automatic tick();
    @(negedge CLK_50);
    check("lo.key_state",   io_lo.key_state,   m_state);
    check("lo.key_press",   io_lo.key_press,   m_press);
    check("lo.key_release", io_lo.key_release, m_rel);
    check("lo.key_long",    io_lo.key_long,    m_long);
    check("lo.key_any",     io_lo.key_any,     |m_state);
    check("hi.key_state",   io_hi.key_state,   m_state);
    check("hi.key_press",   io_hi.key_press,   m_press);
    check("hi.key_release", io_hi.key_release, m_rel);
    check("hi.key_long",    io_hi.key_long,    m_long);
    check("hi.key_any",     io_hi.key_any,     |m_state);
    for (int k = 0; k < NK; k++) begin
      press_cnt[k] += int'(io_lo.key_press[k]);
      rel_cnt[k]   += int'(io_lo.key_release[k]);
      long_cnt[k]  += int'(io_lo.key_long[k]);
    end
  endtask

  // Counts falling edges until the chosen pulse shows on key k (bounded).
  // kind: 0 = press, 1 = release, 2 = long.
  task automatic wait_pulse(input int kind, input int k, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 80) begin
      tick();
      n++;
      case (kind)
        0:       hit = io_lo.key_press[k];
        1:       hit = io_lo.key_release[k];
        default: hit = io_lo.key_long[k];
      endcase
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".lo_out"}, {io_lo.key_state, io_lo.key_press, io_lo.key_release, io_lo.key_long, 3'b0, io_lo.key_any}, '0);
    check({tag, ".hi_out"}, {io_hi.key_state, io_hi.key_press, io_hi.key_release, io_hi.key_long, 3'b0, io_hi.key_any}, '0);
  endtask

  int n;
  int remain[NK];

  initial begin
    clear_counts();

    // Reset state.
    repeat (3) tick();
    check_all_zero("reset");
    RST = 1'b0;
    repeat (4) tick();

    // Clean press/release on key 0. Pin changes just before edge E; the
    // pulse is visible after edge E+DEB+1, i.e. at the (DEB+2)th fall.
    clear_counts();
    pressed[0] = 1'b1;
    wait_pulse(0, 0, n);
    check("clean.press_lat", n, DEB + 2);
    check("clean.key_any", io_lo.key_any, 1'b1);
    repeat (10) tick();
    pressed[0] = 1'b0;
    wait_pulse(1, 0, n);
    check("clean.release_lat", n, DEB + 2);
    check("clean.others_quiet", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);
    repeat (4) tick();

    // Bounce rejected on press.
    clear_counts();
    pressed[1] = 1'b1; repeat (5) tick();
    pressed[1] = 1'b0; repeat (2) tick();
    pressed[1] = 1'b1; repeat (5) tick();
    pressed[1] = 1'b0; repeat (12) tick();
    check("bounce.no_press", press_cnt[1], 0);
    check("bounce.state", io_lo.key_state[1], 1'b0);

    // Bounce rejected on release of a held key.
    pressed[1] = 1'b1;
    wait_pulse(0, 1, n);
    repeat (5) tick();
    pressed[1] = 1'b0; repeat (5) tick();
    pressed[1] = 1'b1; repeat (2) tick();
    pressed[1] = 1'b0; repeat (5) tick();
    pressed[1] = 1'b1; repeat (12) tick();
    check("bounce.no_release", rel_cnt[1], 0);
    check("bounce.still_held", io_lo.key_state[1], 1'b1);
    pressed[1] = 1'b0;
    wait_pulse(1, 1, n);
    repeat (4) tick();

    // Long press on key 2: a single key_long LONG edges after key_press.
    clear_counts();
    pressed[2] = 1'b1;
    wait_pulse(0, 2, n);
    wait_pulse(2, 2, n);
    check("long.latency", n, LONG);
    repeat (20) tick();
    pressed[2] = 1'b0;
    wait_pulse(1, 2, n);
    check("long.release_lat", n, DEB + 2);
    repeat (40) tick();
    check("long.single_pulse", long_cnt[2], 1);

    // Short hold: pin held 30 cycles, no long press.
    clear_counts();
    pressed[2] = 1'b1; repeat (30) tick();
    pressed[2] = 1'b0; repeat (20) tick();
    check("short.press", press_cnt[2], 1);
    check("short.no_long", long_cnt[2], 0);

    // Simultaneous presses on keys 0 and 3.
    clear_counts();
    pressed[0] = 1'b1; pressed[3] = 1'b1;
    wait_pulse(0, 0, n);
    check("simul.press3_same_cycle", io_lo.key_press[3], 1'b1);
    check("simul.hi_press", io_hi.key_press, 4'b1001);
    repeat (5) tick();
    pressed[0] = 1'b0;
    wait_pulse(1, 0, n);
    check("simul.any_one_left", io_lo.key_any, 1'b1);
    repeat (6) tick();
    pressed[3] = 1'b0;
    wait_pulse(1, 3, n);
    check("simul.any_cleared", io_lo.key_any, 1'b0);
    repeat (4) tick();

    // Reset in the middle of a pending press, key held across reset.
    clear_counts();
    pressed[1] = 1'b1;
    repeat (3) tick();
    RST = 1'b1;
    #1;
    check_all_zero("rst_pending");
    repeat (2) tick();
    RST = 1'b0;
    wait_pulse(0, 1, n);
    check("rst_pending.press_lat", n, DEB + 2);
    check("rst_pending.one_press", press_cnt[1], 1);

    // Reset in the middle of a hold, key released during reset.
    repeat (10) tick();
    RST = 1'b1;
    #1;
    check_all_zero("rst_hold");
    tick();
    pressed[1] = 1'b0;
    RST = 1'b0;
    repeat (LONG + 10) tick();
    check("rst_hold.no_release", rel_cnt[1], 0);
    check("rst_hold.no_long", long_cnt[1], 0);

    // Randomized activity on all keys, including bounces and long holds.
    for (int k = 0; k < NK; k++) remain[k] = int'($urandom_range(1, 20));
    repeat (1500) begin
      for (int k = 0; k < NK; k++) begin
        if (remain[k] == 0) begin
          pressed[k] = ~pressed[k];
          remain[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 50))
                                                   : int'($urandom_range(1, 14));
        end else begin
          remain[k]--;
        end
      end
      if ($urandom_range(0, 299) == 0) begin
        RST = 1'b1;
        tick();
        RST = 1'b0;
      end
      tick();
    end
    pressed = '0;
    repeat (20) tick();
    check("final.all_released", io_lo.key_state, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
